// File: rtl/cmp_pkg.sv
// Shared definitions for the max-comparator datapath: loader, comparator and flag capture.
package cmp_pkg;

    localparam int unsigned CMP_DATA_W  = 4;
    localparam int unsigned CMP_NUM_OPS = 4;

    typedef enum logic {
        LDR_COLLECT,
        LDR_HOLD
    } ldr_state_t;

    typedef logic [1:0] slot_idx_t;

endpackage

// File: rtl/cmp_operand_loader.sv
// Serial-to-parallel operand loader: assembles four beats into a held frame a..d.
// Optional frame counter and resync error pulse via `define CMP_LOADER_FRAME_CNT_EN.
module cmp_operand_loader
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_W          = CMP_DATA_W,
    parameter bit          RESYNC_ON_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_first,
    output logic              in_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
`ifdef CMP_LOADER_FRAME_CNT_EN
    output logic [7:0]        frame_cnt,
    output logic              resync_err,
`endif
    output logic              out_valid,
    input  logic              out_ready
);

    ldr_state_t        state_q, state_d;
    slot_idx_t         idx_q, idx_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;
    logic              resync;

    assign in_ready = (state_q == LDR_COLLECT);
    assign accept   = in_valid & in_ready;
    assign resync   = RESYNC_ON_FIRST && accept && in_first;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            LDR_COLLECT: begin
                if (resync) begin
                    // Restart at slot a; stale slots get overwritten as the frame refills.
                    a_d   = in_data;
                    idx_d = 2'd1;
                end else if (accept) begin
                    unique case (idx_q)
                        2'd0: a_d = in_data;
                        2'd1: b_d = in_data;
                        2'd2: c_d = in_data;
                        2'd3: d_d = in_data;
                        default: ;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = LDR_HOLD;
                        out_valid_d = 1'b1;
                    end
                end
            end
            LDR_HOLD: begin
                if (out_ready) begin
                    state_d     = LDR_COLLECT;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = LDR_COLLECT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LDR_COLLECT;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign out_valid = out_valid_q;

`ifdef CMP_LOADER_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;
    logic       resync_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            resync_err_q <= 1'b0;
        end else begin
            if (state_q == LDR_HOLD && out_ready) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            resync_err_q <= resync && (idx_q != 2'd0);
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign resync_err = resync_err_q;
`endif

endmodule
